// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the LSU store queue.
//   SZ_BYTE/SZ_HALF/SZ_WORD  request size codes
//   drain_e                  drain state encoding (D_IDLE/D_READ/D_WRITE)
//   sq_entry_t               queued store: word address, byte mask, lane-aligned data, pc4
//   lane_of/size_mask/lane_shift/mask_bits  helpers for building and merging entries
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_READ  = 2'd1,
    D_WRITE = 2'd2
  } drain_e;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] pc4;
  } sq_entry_t;

  // Misaligned halves/words are truncated to their natural boundary.
  function automatic logic [1:0] lane_of(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: lane_of = a;
      SZ_HALF: lane_of = {a[1], 1'b0};
      default: lane_of = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: size_mask = 4'b0001 << a;
      SZ_HALF: size_mask = 4'b0011 << {a[1], 1'b0};
      default: size_mask = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] lane_shift(input logic [31:0] data, input logic [1:0] lane);
    lane_shift = data << {lane, 3'b000};
  endfunction

  function automatic logic [31:0] mask_bits(input logic [3:0] m);
    mask_bits = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/lsu_store_queue_sq_fifo.sv
// sq_fifo: DEPTH-entry store FIFO.
//   push/push_entry  enqueue (ignored when full)
//   pop              dequeue head (ignored when empty)
//   full/empty/head  status and oldest entry
//   match_waddr      word address compared against every valid entry -> match_vec
module sq_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  sq_entry_t        push_entry,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output sq_entry_t        head,
  input  logic [29:0]      match_waddr,
  output logic [DEPTH-1:0] match_vec
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sq_entry_t        mem_q [DEPTH];
  sq_entry_t        mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (count_q == CNT_W'(DEPTH));
    empty   = (count_q == '0);
    head    = mem_q[rd_ptr_q];
    do_push = push && !full;
    do_pop  = pop && !empty;

    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q]   = push_entry;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid_q[i] && (mem_q[i].waddr == match_waddr);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: valid_q qualifies every entry.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/lsu_store_queue.sv
// lsu_store_queue: MEM-stage initiator for a word-only data memory port.
//   req_*        pipeline memory op (store/load, size, sign, address, data, pc4)
//   stall        op not taken this cycle
//   ld_data      extended load result (combinational, valid when a load is taken)
//   align_err    misaligned half/word, only when LSU_ALIGN_CHECK_EN is defined
//   dm_*         word-wide memory port; dm_rd is combinational read data
// Build option: LSU_ALIGN_CHECK_EN rejects misaligned ops instead of truncating.
//
// Drain states:
//   state   | meaning
//   D_IDLE  | head is full word: write and pop; sub-word: go read it
//   D_READ  | read head word, latch merged data (aborted by a taken load)
//   D_WRITE | write merged word, pop; owns the port unconditionally
module lsu_store_queue
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc4,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        align_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_wren,
  output logic [31:0] dm_pc4,
  input  logic [31:0] dm_rd
);

  drain_e           state_q, state_d;
  logic [31:0]      merge_q, merge_d;
  sq_entry_t        push_entry, head;
  logic             push, pop, full, empty;
  logic [DEPTH-1:0] match_vec;
  logic             misal, is_load, is_store, load_stall, load_taken, wren_c;
  logic [31:0]      rd_sh, head_m;

  sq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .full        (full),
    .empty       (empty),
    .head        (head),
    .match_waddr (req_addr[31:2]),
    .match_vec   (match_vec)
  );

  always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
    misal = req_valid && (((req_size == SZ_HALF) && req_addr[0]) ||
                          ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)));
`else
    misal = 1'b0;
`endif
    is_load    = req_valid && !req_we && !misal;
    is_store   = req_valid && req_we && !misal;
    load_stall = is_load && ((|match_vec) || (state_q == D_WRITE));
    load_taken = is_load && !load_stall;
    push       = is_store && !full;

    push_entry.waddr = req_addr[31:2];
    push_entry.mask  = size_mask(req_size, req_addr[1:0]);
    push_entry.data  = lane_shift(req_wdata, lane_of(req_size, req_addr[1:0]));
    push_entry.pc4   = req_pc4;

    head_m   = mask_bits(head.mask);
    pop      = 1'b0;
    wren_c   = 1'b0;
    state_d  = state_q;
    merge_d  = merge_q;
    dm_addr  = {head.waddr, 2'b00};
    dm_wdata = head.data;
    dm_pc4   = head.pc4;

    if (state_q == D_WRITE) begin
      wren_c   = 1'b1;
      dm_wdata = merge_q;
      pop      = 1'b1;
      state_d  = D_IDLE;
    end else if (load_taken) begin
      // Load steals the port; a pending read is abandoned and redone later.
      dm_addr = req_addr;
      dm_pc4  = req_pc4;
      state_d = D_IDLE;
    end else if (state_q == D_READ) begin
      merge_d = (dm_rd & ~head_m) | (head.data & head_m);
      state_d = D_WRITE;
    end else if (!empty) begin
      if (head.mask == 4'hF) begin
        wren_c = 1'b1;
        pop    = 1'b1;
      end else begin
        state_d = D_READ;
      end
    end

    rd_sh   = dm_rd;
    ld_data = dm_rd;
    case (req_size)
      SZ_BYTE: begin
        rd_sh   = dm_rd >> {req_addr[1:0], 3'b000};
        ld_data = {{24{req_sign & rd_sh[7]}}, rd_sh[7:0]};
      end
      SZ_HALF: begin
        rd_sh   = dm_rd >> {req_addr[1], 4'b0000};
        ld_data = {{16{req_sign & rd_sh[15]}}, rd_sh[15:0]};
      end
      default: ld_data = dm_rd;
    endcase

    // Reset masks the handshake/strobe outputs in the same cycle.
    stall     = (load_stall || (is_store && full)) && reset;
    dm_wren   = wren_c && reset;
    align_err = misal && reset;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= D_IDLE;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
    end
  end

endmodule

// File: tb/tb_lsu_store_queue.sv
module tb_lsu_store_queue;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0, req_pc4 = '0;
  logic        stall, align_err, dm_wren;
  logic [31:0] ld_data, dm_addr, dm_wdata, dm_pc4, dm_rd;

  logic        dm_clr = 1'b1;
  logic [31:0] dm_mem  [0:63];
  logic [31:0] ref_mem [0:63];
  int n_tests = 0;
  int n_fail  = 0;
  localparam int BUDGET = 50;

  always #5 clk = ~clk;

  lsu_store_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc4(req_pc4), .stall(stall), .ld_data(ld_data),
    .align_err(align_err), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wren(dm_wren), .dm_pc4(dm_pc4), .dm_rd(dm_rd)
  );

  // Data memory: combinational read, word write on the clock edge.
  always @(posedge clk) begin
    if (dm_clr) begin
      for (int i = 0; i < 64; i++) dm_mem[i] <= '0;
    end else if (dm_wren) begin
      dm_mem[dm_addr[7:2]] <= dm_wdata;
    end
  end
  assign dm_rd = dm_mem[dm_addr[7:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-addressed reference memory, updated in program order.
  function automatic logic [7:0] get_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[a[7:2]];
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
    ref_mem[a[7:2]][{a[1:0], 3'b000} +: 8] = v;
  endtask

  function automatic logic ref_misal(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_ALIGN_CHECK_EN
    return ((sz == SZ_HALF) && a[0]) || ((sz == SZ_WORD) && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] ea;
    if (sz == SZ_BYTE) begin
      set_byte(a, wd[7:0]);
    end else if (sz == SZ_HALF) begin
      ea = {a[31:1], 1'b0};
      set_byte(ea, wd[7:0]);
      set_byte(ea + 1, wd[15:8]);
    end else begin
      ea = {a[31:2], 2'b00};
      for (int k = 0; k < 4; k++) set_byte(ea + k, wd[8*k +: 8]);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [31:0] ea;
    logic [7:0]  b;
    logic [15:0] h;
    if (sz == SZ_BYTE) begin
      b = get_byte(a);
      return sg ? {{24{b[7]}}, b} : {24'h0, b};
    end else if (sz == SZ_HALF) begin
      ea = {a[31:1], 1'b0};
      h  = {get_byte(ea + 1), get_byte(ea)};
      return sg ? {{16{h[15]}}, h} : {16'h0, h};
    end
    ea = {a[31:2], 2'b00};
    return {get_byte(ea + 3), get_byte(ea + 2), get_byte(ea + 1), get_byte(ea)};
  endfunction

  // Present an op at posedge+1, hold it until not stalled, return after the taking edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] ld, output logic ae, output logic [31:0] pc_seen,
                       output logic [31:0] pc_sent, output int waits);
    req_valid = 1'b1; req_we = we; req_size = sz; req_sign = sg;
    req_addr = a; req_wdata = wd; req_pc4 = $urandom;
    pc_sent = req_pc4;
    waits = 0;
    @(negedge clk);
    while (stall && waits < BUDGET) begin
      @(negedge clk);
      waits++;
    end
    ld = ld_data; ae = align_err; pc_seen = dm_pc4;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_op(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] ld, output int waits);
    logic ae, mis;
    logic [31:0] pcs, pct;
    issue(we, sz, sg, a, wd, ld, ae, pcs, pct, waits);
    mis = ref_misal(sz, a);
    chk("op_wait_bound", {31'h0, waits < BUDGET}, 32'h1);
    chk("align_err", {31'h0, ae}, {31'h0, mis});
    if (!mis) begin
      if (we) begin
        ref_store(sz, a, wd);
      end else begin
        chk("load_data", ld, ref_load(sz, sg, a));
        chk("load_pc4", pcs, pct);
      end
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ld, pcs, pct;
    logic        ae;
    int          w, nwr;

    for (int i = 0; i < 64; i++) ref_mem[i] = '0;

    // Reset: outputs quiet even with a request presented.
    reset = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_addr = 32'h10; req_wdata = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_wren", {31'h0, dm_wren}, 32'h0);
    chk("rst_align", {31'h0, align_err}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1; dm_clr = 1'b0; req_valid = 1'b0;

    // 1: store then dependent load stalls one cycle.
    do_op(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, ld, w);
    chk("t1_sw_wait", w, 0);
    do_op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, ld, w);
    chk("t1_lw_wait", w, 1);
    chk("t1_lw_data", ld, 32'hDEADBEEF);

    // 2: byte store becomes read-modify-write.
    do_op(1'b1, SZ_WORD, 1'b0, 32'h14, 32'h11223344, ld, w);
    idle(6);
    do_op(1'b1, SZ_BYTE, 1'b0, 32'h17, 32'h000000AB, ld, w);
    @(negedge clk);
    chk("t2_idle_wren", {31'h0, dm_wren}, 32'h0);
    @(negedge clk);
    chk("t2_read_wren", {31'h0, dm_wren}, 32'h0);
    chk("t2_read_addr", dm_addr, 32'h14);
    @(negedge clk);
    chk("t2_write_wren", {31'h0, dm_wren}, 32'h1);
    chk("t2_write_data", dm_wdata, 32'hAB223344);
    @(posedge clk); #1;
    do_op(1'b0, SZ_BYTE, 1'b1, 32'h17, 32'h0, ld, w);
    chk("t2_lb", ld, 32'hFFFFFFAB);
    do_op(1'b0, SZ_BYTE, 1'b0, 32'h17, 32'h0, ld, w);
    chk("t2_lbu", ld, 32'h000000AB);

    // 3: loads between sub-word stores keep aborting the drain; 5th store waits.
    begin
      logic [31:0] st_addr [5];
      st_addr = '{32'h30, 32'h34, 32'h38, 32'h3C, 32'h2C};
      for (int i = 0; i < 5; i++) begin
        do_op(1'b1, SZ_BYTE, 1'b0, st_addr[i], 32'h60 + i, ld, w);
        chk("t3_store_wait", w, (i == 4) ? 3 : 0);
        if (i < 4) begin
          do_op(1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, ld, w);
          chk("t3_load_wait", w, 0);
        end
      end
    end
    idle(30);

    // 4: load during D_READ aborts; write comes later.
    do_op(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h00005566, ld, w);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_sign = 1'b0;
    req_addr = 32'h40; req_pc4 = 32'h1234;
    @(negedge clk);
    chk("t4_ld_stall", {31'h0, stall}, 32'h0);
    chk("t4_ld_wren", {31'h0, dm_wren}, 32'h0);
    chk("t4_ld_addr", dm_addr, 32'h40);
    chk("t4_ld_pc4", dm_pc4, 32'h1234);
    chk("t4_ld_data", ld_data, ref_load(SZ_WORD, 1'b0, 32'h40));
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("t4_after_abort_wren", {31'h0, dm_wren}, 32'h0);
    @(negedge clk);
    chk("t4_reread_wren", {31'h0, dm_wren}, 32'h0);
    chk("t4_reread_addr", dm_addr, 32'h20);
    @(negedge clk);
    chk("t4_write_wren", {31'h0, dm_wren}, 32'h1);
    chk("t4_write_upper", {16'h0, dm_wdata[31:16]}, 32'h5566);
    chk("t4_write_word", dm_wdata, ref_mem[8]);
    @(posedge clk); #1;

    // 5: reset during D_WRITE drops everything queued.
    issue(1'b1, SZ_BYTE, 1'b0, 32'h50, 32'h11, ld, ae, pcs, pct, w);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h54, 32'h22, ld, ae, pcs, pct, w);
    issue(1'b1, SZ_BYTE, 1'b0, 32'h58, 32'h33, ld, ae, pcs, pct, w);
    reset = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_addr = 32'h5C; req_wdata = 32'h44;
    @(negedge clk);
    chk("t5_rst_wren", {31'h0, dm_wren}, 32'h0);
    chk("t5_rst_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 1'b0;
    nwr = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dm_wren) nwr++;
    end
    @(posedge clk); #1;
    chk("t5_no_writes", nwr, 0);
    for (int i = 20; i < 24; i++) chk("t5_mem_untouched", dm_mem[i], ref_mem[i]);
    do_op(1'b0, SZ_WORD, 1'b0, 32'h50, 32'h0, ld, w);
    chk("t5_load_wait", w, 0);

    // 6: misaligned half ops.
    do_op(1'b1, SZ_HALF, 1'b0, 32'h13, 32'h00007788, ld, w);
    do_op(1'b0, SZ_HALF, 1'b1, 32'h11, 32'h0, ld, w);
`ifndef LSU_ALIGN_CHECK_EN
    chk("t6_lh_trunc", ld, 32'hFFFFBEEF);
`else
    chk("t6_no_wait", w, 0);
`endif
    idle(10);
    chk("t6_mem_word4", dm_mem[4], ref_mem[4]);

    // Random traffic against the reference memory.
    for (int i = 0; i < 400; i++) begin
      logic        we, sg;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63));
      wd = $urandom;
      do_op(we, sz, sg, a, wd, ld, w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    idle(40);
    for (int i = 0; i < 16; i++) chk("final_mem", dm_mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
